// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and state encoding for the TDM demux.
// Macro TDM_DEMUX_PARITY_EN selects the 17-slot frame with an even-parity slot.
package tdm_pkg;
  localparam int SLOTS = 16;
  localparam int SEL_W = 4;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME_LEN = 17;
  localparam int CNT_W = 5;
`else
  localparam int FRAME_LEN = 16;
  localparam int CNT_W = 4;
`endif
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/dec4to16_en.sv
// dec4to16_en: 4-to-16 one-hot decoder with enable; bit i set when i_en and i_sel == i.
module dec4to16_en
  import tdm_pkg::*;
(
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_en,
  output logic [SLOTS-1:0] o_dec
);
  assign o_dec = i_en ? SLOTS'(1) << i_sel : '0;
endmodule

// File: rtl/tdm_demux16.sv
// tdm_demux16: serial-to-parallel TDM demux, 16 slots aligned by a frame-sync marker.
// Macro TDM_DEMUX_PARITY_EN adds a 17th even-parity slot and the parity_err output.
module tdm_demux16
  import tdm_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             en,
  input  logic             din,
  input  logic             sync,
  output logic [0:SLOTS-1] W,
  output logic             f_valid,
  output logic [SEL_W-1:0] S16,
`ifdef TDM_DEMUX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             err
);
  state_t r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [0:SLOTS-1] r_shadow, w_word;
  logic [SLOTS-1:0] w_dec;
  logic [SEL_W-1:0] w_sel;
  logic w_take, w_last, w_frame, w_bad, w_ok, w_wr;
  always_comb begin
    w_last = r_cnt == CNT_W'(FRAME_LEN - 1);
    w_take = en & (r_state == IDLE ? sync : (sync | (r_cnt != '0)));
    w_bad = en & (r_state == RUN) & (sync ? (r_cnt != '0) : (r_cnt == '0));
    w_frame = en & (r_state == RUN) & ~sync & w_last;
    w_state_n = (r_state == IDLE) ? ((en & sync) ? RUN : IDLE) : ((en & ~sync & (r_cnt == '0)) ? IDLE : RUN);
    w_cnt_n = ~w_take ? r_cnt : sync ? CNT_W'(1) : w_last ? '0 : r_cnt + CNT_W'(1);
    w_sel = sync ? '0 : r_cnt[SEL_W-1:0];
  end
`ifdef TDM_DEMUX_PARITY_EN
  assign w_wr = w_take & (sync | ~r_cnt[SEL_W]);
  assign w_word = r_shadow;
  assign w_ok = ~^{r_shadow, din};
`else
  assign w_wr = w_take;
  // the last slot bypasses the shadow so the frame lands on the same edge as its final bit
  assign w_word = w_dec[SLOTS-1] ? {r_shadow[0:SLOTS-2], din} : r_shadow;
  assign w_ok = 1'b1;
`endif
  dec4to16_en u_dec (.i_sel(w_sel), .i_en(w_wr), .o_dec(w_dec));
  assign S16 = r_cnt[SEL_W-1:0];
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_shadow <= '0;
      W <= '0;
      f_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt <= w_cnt_n;
      for (int i = 0; i < SLOTS; i++) if (w_dec[i]) r_shadow[i] <= din;
      if (w_frame & w_ok) W <= w_word;
      f_valid <= w_frame & w_ok;
      err <= w_bad;
    end
  end
`ifdef TDM_DEMUX_PARITY_EN
  always_ff @(posedge Clock) parity_err <= ~Reset & w_frame & ~w_ok;
`endif
endmodule

// File: tb/tb_tdm_demux16.sv
// tb_tdm_demux16: frame table, corner-case sequences and random traffic against a queue-based model.
module tb_tdm_demux16;
  logic Clock = 1'b0;
  logic Reset, en, din, sync;
  logic [0:15] W;
  logic f_valid, err;
  logic [3:0] S16;
  int checks = 0, errors = 0;
  int fv_count = 0, err_count = 0;
  bit m_al = 0;
  bit m_bits[$];
  logic [15:0] m_w = '0;
  bit m_fv, m_err;

  typedef struct {logic [15:0] word; bit gap; logic [15:0] exp_w;} vec_t;
  vec_t tbl[4];

  tdm_demux16 dut (.Clock(Clock), .Reset(Reset), .en(en), .din(din), .sync(sync),
                   .W(W), .f_valid(f_valid), .S16(S16), .err(err));

  always #5 Clock = ~Clock;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // frame-level model: a queue of bits received since the last slot-0 marker
  task automatic model(bit r, bit e, bit d, bit s);
    m_fv = 0;
    m_err = 0;
    if (r) begin
      m_al = 0;
      m_bits.delete();
      m_w = '0;
      return;
    end
    if (!e) return;
    if (!m_al) begin
      if (s) begin
        m_al = 1;
        m_bits = {d};
      end
      return;
    end
    if (s) begin
      m_err = m_bits.size() != 0;
      m_bits = {d};
      return;
    end
    if (m_bits.size() == 0) begin
      m_err = 1;
      m_al = 0;
      return;
    end
    m_bits.push_back(d);
    if (m_bits.size() == 16) begin
      for (int i = 0; i < 16; i++) m_w[15-i] = m_bits[i];
      m_fv = 1;
      m_bits.delete();
    end
  endtask

  task automatic step(bit r, bit e, bit d, bit s);
    Reset = r;
    en = e;
    din = d;
    sync = s;
    @(posedge Clock);
    model(r, e, d, s);
    #1;
    chk("W", W, m_w);
    chk("f_valid", f_valid, m_fv);
    chk("err", err, m_err);
    chk("S16", S16, m_al ? m_bits.size() % 16 : 0);
    fv_count += int'(f_valid);
    err_count += int'(err);
  endtask

  task automatic send(logic [15:0] w, bit gap);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, w[15-i], i == 0);
      if (gap) step(0, 0, 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    int fc, ec;
    tbl[0] = '{16'hA5C3, 1'b0, 16'hA5C3};
    tbl[1] = '{16'hA5C3, 1'b1, 16'hA5C3};
    tbl[2] = '{16'hFFFF, 1'b0, 16'hFFFF};
    tbl[3] = '{16'h0001, 1'b0, 16'h0001};

    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    chk("rst_W", W, 16'h0);
    chk("rst_S16", S16, 4'h0);
    step(0, 1, 1, 0);
    chk("idle_ignore_S16", S16, 4'h0);

    for (int k = 0; k < 4; k++) begin
      fc = fv_count;
      send(tbl[k].word, tbl[k].gap);
      chk("tbl_W", W, tbl[k].exp_w);
      chk("tbl_fv_pulses", 16'(fv_count - fc), 16'd1);
    end

    ec = err_count;
    step(0, 1, 1, 0);
    chk("nosync_err", err, 1'b1);
    chk("nosync_W_kept", W, 16'h0001);
    step(0, 1, 1, 0);
    chk("idle_no_err", err, 1'b0);
    send(16'h3C5A, 0);
    chk("realign_W", W, 16'h3C5A);
    chk("nosync_err_count", 16'(err_count - ec), 16'd1);

    for (int i = 0; i < 7; i++) step(0, 1, 1'($urandom), i == 0);
    chk("early_pre_S16", S16, 4'd7);
    ec = err_count;
    fc = fv_count;
    send(16'h1234, 0);
    chk("early_err_count", 16'(err_count - ec), 16'd1);
    chk("early_fv_count", 16'(fv_count - fc), 16'd1);
    chk("early_W", W, 16'h1234);

    for (int i = 0; i < 9; i++) step(0, 1, 1, i == 0);
    step(1, 1, 1, 1);
    chk("midrst_W", W, 16'h0);
    chk("midrst_S16", S16, 4'h0);
    fc = fv_count;
    for (int i = 0; i < 20; i++) step(0, 1, 1, 0);
    chk("midrst_ignored_S16", S16, 4'h0);
    chk("midrst_no_fv", 16'(fv_count - fc), 16'd0);

    for (int n = 0; n < 3000; n++) begin
      bit s;
      s = (!m_al || m_bits.size() == 0) ? ($urandom % 8 != 0) : ($urandom % 40 == 0);
      step($urandom % 250 == 0, $urandom % 10 < 7, 1'($urandom), s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tdm_demux16.md
Name: tdm_demux16

Overview:
- Receive-side time-division demultiplexer: takes a serial bit stream framed into 16 slots and distributes each slot bit to its own parallel output bit W[0:15].
- Counterpart of the 16:1 selection logic that serializes a 16-bit word onto one line.
- Slot selection is driven by an internal 4-bit slot counter aligned by a frame-sync marker.
- Sits between a serial link input and parallel consumer logic; delivers one registered 16-bit frame per 16 accepted bits.

Parameters:
- SLOTS, 16, number of slots per frame (fixed by design; width checks assume 16).
- SEL_W, 4, slot counter width, log2(SLOTS).

Ports:
- Clock  in  1  single system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- en  in  1  bit strobe; din/sync are sampled only on cycles with en=1.
- din  in  1  serial data bit for the current slot.
- sync  in  1  frame marker; 1 marks din as slot 0 of a new frame.
- W  out  [0:15]  last complete frame; W[i] = bit received in slot i.
- f_valid  out  1  one-cycle pulse when W is updated.
- S16  out  [3:0]  slot index the next accepted bit will land in.
- err  out  1  one-cycle pulse on framing error.

Behaviour:
- Reset (Reset=1 at an edge): W=0, shadow register=0, S16=0, f_valid=0, err=0, state=IDLE. Reset mid-frame discards the partial frame; W keeps no old data.
- State IDLE (unaligned):
  - en=0 or sync=0: hold; no output change.
  - en=1 and sync=1: shadow[0]<=din, S16<=1, go to RUN.
- State RUN, en=0: hold all state; f_valid=0, err=0.
- State RUN, en=1, sync=0, S16 in 1..14: shadow[S16]<=din, S16<=S16+1.
- State RUN, en=1, sync=0, S16=15:
  - W<={shadow[0:14],din} at this edge, so f_valid=1 in the following cycle (latency 1 edge from the last bit).
  - S16 wraps to 0; stay in RUN.
- State RUN, en=1, S16=0: sync must be 1.
  - sync=1: shadow[0]<=din, S16<=1.
  - sync=0: err pulse, go to IDLE, bit dropped.
- State RUN, en=1, sync=1, S16 in 1..15 (early sync):
  - Partial frame discarded; err pulse.
  - Bit taken as slot 0: shadow[0]<=din, S16<=1; stay in RUN.
  - W is not updated.
- f_valid and err are registered, are never both 1, and each lasts exactly one cycle.
- W is stable between f_valid pulses.
- Simultaneous Reset and en: Reset wins.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- With the macro defined:
  - The frame is 17 slots; slot 16 carries even parity over slots 0..15.
  - S16 widens to 5 bits internally; the port S16 reports [3:0] plus a new output parity_err.
  - On the slot-16 bit, W is updated and f_valid pulses only if parity matches.
  - On mismatch: W is held, parity_err pulses 1 cycle, and the state stays in RUN.
- Without the macro: 16-slot frame as above; no parity_err port.

Decomposition:
- Package tdm_pkg holds:
  - SLOTS and SEL_W constants.
  - State encoding: IDLE=1'b0, RUN=1'b1.
  - FRAME_LEN constant, 16 or 17 under TDM_DEMUX_PARITY_EN.
- One sub-module: dec4to16_en, a 4-to-16 one-hot decoder with enable. It drives the per-slot shadow write enables from S16 and en.

Test Plan:
- Aligned frame: sync=1 on first bit, en=1 continuously, bits 1010_0101_1100_0011 (slot 0 first) -> W=16'hA5C3, f_valid single pulse 1 cycle after bit 16, err=0.
- Gapped strobe: same frame with en=0 on every other cycle -> identical W=16'hA5C3; S16 holds during gaps.
- Back-to-back frames: 16'hFFFF then 16'h0001, with sync on each slot 0 -> two f_valid pulses 16 en-cycles apart, W=FFFF then 0001.
- Missing sync at slot 0 after a good frame -> err pulse, IDLE, W retains the previous value; the next sync realigns.
- Early sync at slot 7 -> err pulse, partial frame dropped; the following 16 bits land in W correctly.
- Reset asserted at slot 9 -> next cycle W=0, S16=0, IDLE; bits without sync are ignored.
